// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Imported by the top and by the bit timer.
package fifo_uart_tx_pkg;

    localparam int DATA_W          = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int BIT_IDX_W       = 3;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit clock divider: counts CLKS_PER_BIT cycles, pulses bit_done.
// Shared with the future RX side.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    import fifo_uart_tx_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and sends each byte as an 8N1 UART frame.
// A new byte is fetched only after the previous stop bit ends.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_wr,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy
);

    import fifo_uart_tx_pkg::*;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [DATA_W-1:0]     shift;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic                  bit_done;
    logic                  timer_clear;
    logic                  rd_ok;

    // Write has priority in the FIFO, so a rd is only safe when wr is low.
    assign rd_ok = !fifo_empty && !fifo_wr;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            REQ:     if (rd_ok) state_next = WAIT;
            WAIT:    state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
                    state_next = STOP;
                end
            end
            STOP:    if (bit_done) state_next = REQ;
            default: state_next = REQ;
        endcase
    end

    always_comb begin
        fifo_rd     = 1'b0;
        busy        = 1'b0;
        timer_clear = 1'b0;
        unique case (state)
            REQ: begin
                fifo_rd     = rst && rd_ok;
                timer_clear = 1'b1;
            end
            WAIT: begin
                busy        = rst;
                timer_clear = 1'b1;
            end
            START, DATA, STOP: busy = rst;
            default: timer_clear = 1'b1;
        endcase
    end

    // tx is registered so the line never glitches between bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    tx      <= 1'b1;
                    bit_idx <= '0;
                end
                WAIT: begin
                    shift <= fifo_data;
                    tx    <= 1'b0;
                end
                START: begin
                    if (bit_done) tx <= shift[0];
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
                            tx <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
                STOP:    tx <= 1'b1;
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a 16-deep write-priority FIFO model.
// CLKS_PER_BIT = 4, so each frame is 40 cycles.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_wr;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic [7:0] wr_data;

    logic [7:0] mem [16];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    logic [4:0] cnt = 5'd0;
    int         rd_pulses = 0;
    int         rd_err = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         base;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy)
    );

    assign fifo_empty = (cnt == 5'd0);

    always @(posedge clk) begin
        if (fifo_wr && cnt < 5'd16) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
            cnt     <= cnt + 5'd1;
        end else if (fifo_rd && cnt != 5'd0) begin
            fifo_data <= mem[rp];
            rp        <= rp + 4'd1;
            cnt       <= cnt - 5'd1;
        end
        if (fifo_rd) rd_pulses <= rd_pulses + 1;
        if (fifo_rd && cnt == 5'd0) rd_err <= rd_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_tx"}, 32'(tx), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd"}, 32'(fifo_rd), 32'd0);
    endtask

    // Entered in the REQ cycle where fifo_rd should be high.
    task automatic frame(input logic [7:0] b, input string tag);
        logic exp_tx;
        chk({tag, "_rd"}, 32'(fifo_rd), 32'd1);
        step();
        chk({tag, "_wait_tx"}, 32'(tx), 32'd1);
        chk({tag, "_wait_busy"}, 32'(busy), 32'd1);
        chk({tag, "_wait_rd"}, 32'(fifo_rd), 32'd0);
        for (int i = 0; i < 10 * CPB; i++) begin
            step();
            if (i < CPB) exp_tx = 1'b0;
            else if (i < 9 * CPB) exp_tx = b[(i - CPB) / CPB];
            else exp_tx = 1'b1;
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(exp_tx));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s_rd%0d", tag, i), 32'(fifo_rd), 32'd0);
        end
        step();
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        rst     = 1'b0;
        fifo_wr = 1'b0;
        wr_data = 8'h00;

        // 1: reset with a byte written into the FIFO
        step();
        fifo_wr = 1'b1;
        wr_data = 8'h5A;
        #1;
        idle_chk("rst_c1");
        step();
        fifo_wr = 1'b0;
        #1;
        idle_chk("rst_c2");
        step();
        idle_chk("rst_c3");
        chk("rst_cnt", 32'(cnt), 32'd1);
        rst = 1'b1;
        #1;
        frame(8'h5A, "first");
        chk("first_cnt", 32'(cnt), 32'd0);

        // 2: idle while empty, then a single 0xA5
        for (int i = 0; i < 5; i++) begin
            step();
            idle_chk("empty_idle");
        end
        fifo_wr = 1'b1;
        wr_data = 8'hA5;
        #1;
        chk("a5_wr_rd", 32'(fifo_rd), 32'd0);
        step();
        fifo_wr = 1'b0;
        #1;
        frame(8'hA5, "a5");
        chk("a5_cnt", 32'(cnt), 32'd0);

        // 3: write priority holds off rd for 5 cycles
        for (int k = 0; k < 5; k++) begin
            fifo_wr = 1'b1;
            wr_data = 8'h11 + 8'(k);
            #1;
            chk($sformatf("wrpri_rd%0d", k), 32'(fifo_rd), 32'd0);
            step();
        end
        fifo_wr = 1'b0;
        #1;
        chk("wrpri_cnt", 32'(cnt), 32'd5);
        for (int k = 0; k < 5; k++) frame(8'h11 + 8'(k), "wrpri");
        chk("wrpri_cnt_end", 32'(cnt), 32'd0);

        // 4: back-to-back 0x00 then 0xFF
        fifo_wr = 1'b1;
        wr_data = 8'h00;
        step();
        wr_data = 8'hFF;
        step();
        fifo_wr = 1'b0;
        #1;
        frame(8'h00, "b2b0");
        frame(8'hFF, "b2b1");
        chk("b2b_empty", 32'(fifo_empty), 32'd1);

        // 5: reset during data bit 3 of 0x3C
        fifo_wr = 1'b1;
        wr_data = 8'h3C;
        step();
        fifo_wr = 1'b0;
        #1;
        chk("mid_rd", 32'(fifo_rd), 32'd1);
        step();
        chk("mid_wait_busy", 32'(busy), 32'd1);
        repeat (18) step();
        chk("mid_bit3_tx", 32'(tx), 32'd1);
        chk("mid_bit3_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(fifo_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        idle_chk("mid_rst_edge");
        rst = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            idle_chk("mid_after");
            step();
        end

        // 6: fill 16 bytes, drain in order
        base = rd_pulses;
        for (int k = 0; k < 16; k++) begin
            fifo_wr = 1'b1;
            wr_data = 8'(k);
            #1;
            chk("fill_rd", 32'(fifo_rd), 32'd0);
            step();
        end
        fifo_wr = 1'b0;
        #1;
        chk("fill_cnt", 32'(cnt), 32'd16);
        for (int k = 0; k < 16; k++) frame(8'(k), $sformatf("fill%0d", k));
        chk("fill_cnt_end", 32'(cnt), 32'd0);
        chk("fill_pulses", 32'(rd_pulses - base), 32'd16);
        chk("rd_when_empty", 32'(rd_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
